// File: rtl/seg_disp_pkg.sv
// Shared types and constants for the seven-segment display scheduler:
// FSM states, owner encoding, segment bit order, hex glyph table, round-robin pick.
package seg_disp_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHOW   = 2'd1,
        LINGER = 2'd2
    } state_t;

    localparam logic [1:0] OWN_NONE = 2'd3;

    // Bit positions inside an 8-bit pattern {a,b,c,d,e,f,g,dp}
    localparam int SEG_A_BIT  = 7;
    localparam int SEG_B_BIT  = 6;
    localparam int SEG_C_BIT  = 5;
    localparam int SEG_D_BIT  = 4;
    localparam int SEG_E_BIT  = 3;
    localparam int SEG_F_BIT  = 2;
    localparam int SEG_G_BIT  = 1;
    localparam int SEG_DP_BIT = 0;

    localparam logic [7:0] SEG_HEX_0 = 8'hFC;
    localparam logic [7:0] SEG_HEX_1 = 8'h60;
    localparam logic [7:0] SEG_HEX_2 = 8'hDA;
    localparam logic [7:0] SEG_HEX_3 = 8'hF2;
    localparam logic [7:0] SEG_HEX_4 = 8'h66;
    localparam logic [7:0] SEG_HEX_5 = 8'hB6;
    localparam logic [7:0] SEG_HEX_6 = 8'hBE;
    localparam logic [7:0] SEG_HEX_7 = 8'hE0;
    localparam logic [7:0] SEG_HEX_8 = 8'hFE;
    localparam logic [7:0] SEG_HEX_9 = 8'hF6;
    localparam logic [7:0] SEG_HEX_A = 8'hEE;
    localparam logic [7:0] SEG_HEX_B = 8'h3E;
    localparam logic [7:0] SEG_HEX_C = 8'h9C;
    localparam logic [7:0] SEG_HEX_D = 8'h7A;
    localparam logic [7:0] SEG_HEX_E = 8'h9E;
    localparam logic [7:0] SEG_HEX_F = 8'h8E;

    function automatic logic [7:0] seg_code(input logic [3:0] nib);
        logic [7:0] code;
        case (nib)
            4'h0: code = SEG_HEX_0;
            4'h1: code = SEG_HEX_1;
            4'h2: code = SEG_HEX_2;
            4'h3: code = SEG_HEX_3;
            4'h4: code = SEG_HEX_4;
            4'h5: code = SEG_HEX_5;
            4'h6: code = SEG_HEX_6;
            4'h7: code = SEG_HEX_7;
            4'h8: code = SEG_HEX_8;
            4'h9: code = SEG_HEX_9;
            4'hA: code = SEG_HEX_A;
            4'hB: code = SEG_HEX_B;
            4'hC: code = SEG_HEX_C;
            4'hD: code = SEG_HEX_D;
            4'hE: code = SEG_HEX_E;
            default: code = SEG_HEX_F;
        endcase
        return code;
    endfunction

    // Returns {found, index}: first set bit of req searching upward from ptr, wrapping 2 -> 0.
    function automatic logic [2:0] rr_pick(input logic [2:0] req, input logic [1:0] ptr);
        logic       found;
        logic [1:0] idx;
        logic [2:0] pos;
        found = 1'b0;
        idx   = 2'd0;
        for (int k = 0; k < 3; k++) begin
            pos = {1'b0, ptr} + 3'(k);
            if (pos >= 3'd3) begin
                pos = pos - 3'd3;
            end
            if (!found && req[pos[1:0]]) begin
                found = 1'b1;
                idx   = pos[1:0];
            end
        end
        return {found, idx};
    endfunction

endpackage

// File: rtl/seg_disp_sched_hex_to_seg7.sv
// Combinational hex nibble to seven-segment pattern decode with blanking;
// the decimal point is always dark.
module hex_to_seg7
    import seg_disp_pkg::*;
(
    input  logic [3:0] i_nib,
    input  logic       i_blank,
    output logic [7:0] o_seg
);

    always_comb begin
        o_seg             = seg_code(i_nib);
        o_seg[SEG_DP_BIT] = 1'b0;
        if (i_blank) begin
            o_seg = 8'h00;
        end
    end

endmodule

// File: rtl/seg_disp_sched.sv
// Round-robin owner scheduler for an 8-digit seven-segment display with minimum
// hold and time-slice preemption. Optional digit blinking under macro SEG_BLINK_EN.
module seg_disp_sched
    import seg_disp_pkg::*;
#(
    parameter int N_REQ    = 3,
    parameter int HOLD_CYC = 4,
    parameter int TSLICE   = 16,
    parameter int CNT_W    = 8
) (
    input  logic             iCLK,
    input  logic             nRST,
    input  logic [N_REQ-1:0] iREQ,
    input  logic [31:0]      iDIG0,
    input  logic [31:0]      iDIG1,
    input  logic [31:0]      iDIG2,
    input  logic [7:0]       iBLK0,
    input  logic [7:0]       iBLK1,
    input  logic [7:0]       iBLK2,
`ifdef SEG_BLINK_EN
    input  logic [7:0]       iBLINK0,
    input  logic [7:0]       iBLINK1,
    input  logic [7:0]       iBLINK2,
`endif
    output logic [N_REQ-1:0] oACK,
    output logic [1:0]       oOWN,
    output logic [7:0]       oSEG7,
    output logic [7:0]       oSEG6,
    output logic [7:0]       oSEG5,
    output logic [7:0]       oSEG4,
    output logic [7:0]       oSEG3,
    output logic [7:0]       oSEG2,
    output logic [7:0]       oSEG1,
    output logic [7:0]       oSEG0
);

    localparam logic [CNT_W-1:0] HOLD_M1   = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] SLICE_M1  = CNT_W'(TSLICE - 1);
    localparam logic [CNT_W-1:0] SLICE_SAT = CNT_W'(TSLICE);

    state_t           r_state;
    logic [1:0]       r_own;
    logic [1:0]       r_ptr;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_ack;
    logic [31:0]      r_dig;
    logic [7:0]       r_blk;
    logic [7:0]       r_seg [8];

    logic [2:0]  w_own_mask;
    logic [2:0]  w_others;
    logic        w_own_req;
    logic [2:0]  w_pick_all;
    logic [2:0]  w_pick_oth;
    logic        w_grant;
    logic [1:0]  w_grant_idx;
    logic        w_release;
    logic        w_to_idle;
    logic        w_to_linger;
    logic        w_sample;
    logic [1:0]  w_samp_idx;
    logic [31:0] w_dig_sel;
    logic [7:0]  w_blk_sel;
    logic [7:0]  w_blank_eff;
    logic [7:0]  w_seg [8];

    assign w_own_mask = (r_own == OWN_NONE) ? 3'b000 : (3'b001 << r_own);
    assign w_own_req  = |(iREQ & w_own_mask);
    assign w_others   = iREQ & ~w_own_mask;
    assign w_pick_all = rr_pick(iREQ, r_ptr);
    assign w_pick_oth = rr_pick(w_others, r_ptr);

    // A release (hold expired, owner gone, or slice used up) hands over only to
    // requesters other than the outgoing owner; if none, the display goes dark.
    always_comb begin
        w_grant     = 1'b0;
        w_grant_idx = 2'd0;
        w_release   = 1'b0;
        w_to_idle   = 1'b0;
        w_to_linger = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_pick_all[2]) begin
                    w_grant     = 1'b1;
                    w_grant_idx = w_pick_all[1:0];
                end
            end
            SHOW: begin
                if (!w_own_req) begin
                    if (r_cnt < HOLD_M1) begin
                        w_to_linger = 1'b1;
                    end else begin
                        w_release = 1'b1;
                    end
                end else if ((r_cnt >= SLICE_M1) && (|w_others)) begin
                    w_release = 1'b1;
                end
            end
            LINGER: begin
                if (r_cnt >= HOLD_M1) begin
                    w_release = 1'b1;
                end
            end
            default: ;
        endcase
        if (w_release) begin
            if (w_pick_oth[2]) begin
                w_grant     = 1'b1;
                w_grant_idx = w_pick_oth[1:0];
            end else begin
                w_to_idle = 1'b1;
            end
        end
    end

    assign w_sample   = w_grant || ((r_state == SHOW) && !w_release && !w_to_linger);
    assign w_samp_idx = w_grant ? w_grant_idx : r_own;

    always_comb begin
        case (w_samp_idx)
            2'd1:    begin w_dig_sel = iDIG1; w_blk_sel = iBLK1; end
            2'd2:    begin w_dig_sel = iDIG2; w_blk_sel = iBLK2; end
            default: begin w_dig_sel = iDIG0; w_blk_sel = iBLK0; end
        endcase
    end

    always_ff @(posedge iCLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= IDLE;
            r_own   <= OWN_NONE;
            r_ptr   <= 2'd0;
            r_cnt   <= '0;
            r_ack   <= 3'b000;
            r_dig   <= 32'h0;
            r_blk   <= 8'h00;
        end else begin
            r_ack <= 3'b000;
            if ((r_state != IDLE) && (r_cnt != SLICE_SAT)) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_grant) begin
                r_state <= SHOW;
                r_own   <= w_grant_idx;
                r_ack   <= 3'b001 << w_grant_idx;
                r_cnt   <= '0;
                r_ptr   <= (w_grant_idx == 2'd2) ? 2'd0 : w_grant_idx + 2'd1;
            end else if (w_to_idle) begin
                r_state <= IDLE;
                r_own   <= OWN_NONE;
                r_cnt   <= '0;
            end else if (w_to_linger) begin
                r_state <= LINGER;
            end
            if (w_sample) begin
                r_dig <= w_dig_sel;
                r_blk <= w_blk_sel;
            end
        end
    end

`ifdef SEG_BLINK_EN
    logic [21:0] r_presc;
    logic [7:0]  r_blink;
    logic [7:0]  w_blink_sel;

    always_comb begin
        case (w_samp_idx)
            2'd1:    w_blink_sel = iBLINK1;
            2'd2:    w_blink_sel = iBLINK2;
            default: w_blink_sel = iBLINK0;
        endcase
    end

    always_ff @(posedge iCLK or negedge nRST) begin
        if (!nRST) begin
            r_presc <= '0;
            r_blink <= 8'h00;
        end else begin
            r_presc <= r_presc + 1'b1;
            if (w_sample) begin
                r_blink <= w_blink_sel;
            end
        end
    end

    // Prescaler MSB high is the off phase for blinking digits
    assign w_blank_eff = r_blk | (r_blink & {8{r_presc[21]}});
`else
    assign w_blank_eff = r_blk;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_dec
            hex_to_seg7 u_dec (
                .i_nib   (r_dig[gi*4 +: 4]),
                .i_blank (w_blank_eff[gi]),
                .o_seg   (w_seg[gi])
            );
        end
    endgenerate

    // Registered decode: one cycle behind the sampled data, dark once IDLE is reached
    always_ff @(posedge iCLK or negedge nRST) begin
        if (!nRST) begin
            for (int k = 0; k < 8; k++) begin
                r_seg[k] <= 8'h00;
            end
        end else begin
            for (int k = 0; k < 8; k++) begin
                r_seg[k] <= (r_state == IDLE) ? 8'h00 : w_seg[k];
            end
        end
    end

    assign oACK  = r_ack;
    assign oOWN  = r_own;
    assign oSEG0 = r_seg[0];
    assign oSEG1 = r_seg[1];
    assign oSEG2 = r_seg[2];
    assign oSEG3 = r_seg[3];
    assign oSEG4 = r_seg[4];
    assign oSEG5 = r_seg[5];
    assign oSEG6 = r_seg[6];
    assign oSEG7 = r_seg[7];

endmodule
